// File: rtl/dtc_pulse_gen.sv
// Digital-to-time converter: decodes a 4-bit encoder-format code to N ticks and emits a delayed pulse
// after the next synchronised ref_in rising edge. Optional sticky overrun flag under `DTC_OVERRUN_EN.
module dtc_pulse_gen #(
    parameter logic [31:0] TICK_INC    = 32'h0038FCE2,
    parameter int          PULSE_TICKS = 2              // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ref_in,
    input  logic [3:0]  code,
    input  logic        code_valid,
    output logic        code_ready,
    output logic [15:0] thermo_out,
    output logic        dtc_out,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [1:0]  state_dbg
);

    // Handshake: a code transfers on a rising clk edge where code_valid && code_ready;
    // code_ready is high only in IDLE, so codes offered while busy are simply not taken.

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_TICKS - 1);

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  n_reg;
    logic        dtc_nxt, done_nxt;
    logic        ref_ff1, ref_s, ref_s_d, ref_rise;
    logic        accept;
    logic [32:0] sum;
    logic        tick;
    logic [3:0]  n_dec;
    logic [16:0] thermo_full;

    function automatic logic [3:0] decode_n(input logic [3:0] c);
        if (c == 4'd0)
            return 4'd0;
        else if (c[3])
            return {1'b0, c[2:0]} + 4'd1;
        else
            return c + 4'd8;
    endfunction

    assign n_dec       = decode_n(code);
    assign thermo_full = (17'd1 << n_dec) - 17'd1;
    assign code_ready  = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = code_valid && code_ready;
    assign ref_rise    = ref_s & ~ref_s_d;
    assign state_dbg   = state;

    // Tick is the carry out of the phase accumulator for the current cycle.
    assign sum  = {1'b0, acc} + {1'b0, TICK_INC};
    assign tick = sum[32];

    always_comb begin
        state_nxt = state;
        acc_nxt   = 32'd0;
        cnt_nxt   = cnt;
        dtc_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ARMED;
            end
            ARMED: begin
                if (ref_rise) begin
                    cnt_nxt = 4'd0;
                    if (n_reg == 4'd0) begin
                        state_nxt = PULSE;
                        dtc_nxt   = 1'b1;
                    end else begin
                        state_nxt = DELAY;
                    end
                end
            end
            DELAY: begin
                acc_nxt = sum[31:0];
                if (tick) begin
                    if (cnt + 4'd1 == n_reg) begin
                        state_nxt = PULSE;
                        cnt_nxt   = 4'd0;
                        dtc_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            PULSE: begin
                acc_nxt = sum[31:0];
                dtc_nxt = 1'b1;
                if (tick) begin
                    if (cnt == PULSE_LAST) begin
                        state_nxt = IDLE;
                        acc_nxt   = 32'd0;
                        cnt_nxt   = 4'd0;
                        dtc_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= 32'd0;
            cnt        <= 4'd0;
            n_reg      <= 4'd0;
            thermo_out <= 16'd0;
            dtc_out    <= 1'b0;
            done       <= 1'b0;
            ref_ff1    <= 1'b0;
            ref_s      <= 1'b0;
            ref_s_d    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            dtc_out <= dtc_nxt;
            done    <= done_nxt;
            ref_ff1 <= ref_in;
            ref_s   <= ref_ff1;
            ref_s_d <= ref_s;
            if (accept) begin
                n_reg      <= n_dec;
                thermo_out <= thermo_full[15:0];
            end
        end
    end

`ifdef DTC_OVERRUN_EN
    logic overrun_q;

    // A reference edge arriving mid-conversion is only flagged; timing is left alone.
    always_ff @(posedge clk) begin
        if (!reset)
            overrun_q <= 1'b0;
        else if (accept)
            overrun_q <= 1'b0;
        else if (ref_rise && (state == DELAY || state == PULSE))
            overrun_q <= 1'b1;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
